// File: rtl/event_filter_pkg.sv
// Shared widths, event payload type and tile pin-map positions for the event window denoiser.
package event_filter_pkg;

    localparam int unsigned COORD_W   = 2;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned THR_W     = 2;
    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned SUM_W     = COORD_W + PTR_W;
    localparam int unsigned FILL_W    = $clog2(DEPTH + 1);
    localparam int unsigned EV_W      = 3 * COORD_W;
    localparam int unsigned REJ_CNT_W = 4;

    // ui_in / uio_in / uo_out / uio_out bit positions
    localparam int unsigned EV_LSB        = 0;
    localparam int unsigned EV_VALID_BIT  = 6;
    localparam int unsigned BYPASS_BIT    = 7;
    localparam int unsigned THR_LSB       = 0;
    localparam int unsigned CLR_BIT       = 2;
    localparam int unsigned OUT_VALID_BIT = 6;
    localparam int unsigned REJECT_BIT    = 7;
    localparam int unsigned REJ_CNT_LSB   = 4;

    typedef struct packed {
        logic [COORD_W-1:0] t;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
    } ev_t;

endpackage

// File: rtl/event_window_denoiser_if.sv
// Tile pin bundle: enable, dedicated inputs, bidirectional inputs and all outputs.
interface event_window_denoiser_if;

    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);

endinterface

// File: rtl/event_window_channel.sv
// One coordinate channel: circular window buffer, running sum, next average and outlier flag.
module event_window_channel
    import event_filter_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               wr_en,
    input  logic [PTR_W-1:0]   wr_ptr,
    input  logic               full,
    input  logic [COORD_W-1:0] new_val,
    input  logic [THR_W-1:0]   thr,
    output logic [COORD_W-1:0] avg_next_c,
    output logic               far_c
);

    logic [COORD_W-1:0] buf_q [DEPTH];
    logic [COORD_W-1:0] buf_d [DEPTH];
    logic [SUM_W-1:0]   sum_q;
    logic [SUM_W-1:0]   sum_d;
    logic [SUM_W-1:0]   old_c;
    logic [COORD_W-1:0] avg_cur_c;
    logic [COORD_W-1:0] diff_c;

    // Oldest entry only leaves the sum once the window is full
    assign old_c = full ? SUM_W'(buf_q[wr_ptr]) : '0;

    always_comb begin
        buf_d = buf_q;
        sum_d = sum_q;
        if (clr) begin
            for (int i = 0; i < int'(DEPTH); i++) buf_d[i] = '0;
            sum_d = '0;
        end else if (wr_en) begin
            sum_d          = sum_q + SUM_W'(new_val) - old_c;
            buf_d[wr_ptr]  = new_val;
        end
    end

    // Gate compares against the average of the window as it stands before this event
    always_comb begin
        avg_next_c = COORD_W'(sum_d >> PTR_W);
        avg_cur_c  = COORD_W'(sum_q >> PTR_W);
        diff_c     = (new_val >= avg_cur_c) ? (new_val - avg_cur_c) : (avg_cur_c - new_val);
        far_c      = 32'(diff_c) > 32'(thr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) buf_q[i] <= '0;
            sum_q <= '0;
        end else begin
            buf_q <= buf_d;
            sum_q <= sum_d;
        end
    end

endmodule

// File: rtl/event_window_denoiser.sv
// Windowed-average event denoiser: shared pointer/fill, outlier gate, bypass mux and output registers.
module event_window_denoiser
    import event_filter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    event_window_denoiser_if.slave pins
);

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [REJ_CNT_W-1:0] rej_cnt_q, rej_cnt_d;
    ev_t                  avg_q, avg_d;
    logic                 out_valid_q, out_valid_d;
    logic                 reject_q, reject_d;

    ev_t                  ev_c;
    logic [THR_W-1:0]     thr_c;
    logic                 clr_c, offer_c, bypass_c, full_c, gate_c, reject_c, accept_c;
    logic [COORD_W-1:0]   avg_x_c, avg_y_c, avg_t_c;
    logic                 far_x_c, far_y_c, far_t_c;
    logic                 unused_c;

    assign unused_c = ^pins.uio_in[7:3];

    always_comb begin
        ev_c     = ev_t'(pins.ui_in[EV_LSB +: EV_W]);
        thr_c    = pins.uio_in[THR_LSB +: THR_W];
        bypass_c = pins.ui_in[BYPASS_BIT];
        clr_c    = pins.ena & pins.uio_in[CLR_BIT];
        offer_c  = pins.ena & pins.ui_in[EV_VALID_BIT];
        full_c   = (fill_q == FILL_W'(DEPTH));
        gate_c   = ~bypass_c & full_c & (thr_c != '0);
        reject_c = offer_c & ~clr_c & gate_c & (far_x_c | far_y_c | far_t_c);
        accept_c = offer_c & ~clr_c & ~reject_c;
    end

    event_window_channel u_ch_x (
        .clk(clk), .rst_n(rst_n), .clr(clr_c), .wr_en(accept_c), .wr_ptr(wr_ptr_q),
        .full(full_c), .new_val(ev_c.x), .thr(thr_c), .avg_next_c(avg_x_c), .far_c(far_x_c)
    );

    event_window_channel u_ch_y (
        .clk(clk), .rst_n(rst_n), .clr(clr_c), .wr_en(accept_c), .wr_ptr(wr_ptr_q),
        .full(full_c), .new_val(ev_c.y), .thr(thr_c), .avg_next_c(avg_y_c), .far_c(far_y_c)
    );

    event_window_channel u_ch_t (
        .clk(clk), .rst_n(rst_n), .clr(clr_c), .wr_en(accept_c), .wr_ptr(wr_ptr_q),
        .full(full_c), .new_val(ev_c.t), .thr(thr_c), .avg_next_c(avg_t_c), .far_c(far_t_c)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        rej_cnt_d   = rej_cnt_q;
        avg_d       = avg_q;
        out_valid_d = 1'b0;
        reject_d    = 1'b0;
        if (clr_c) begin
            wr_ptr_d  = '0;
            fill_d    = '0;
            rej_cnt_d = '0;
            avg_d     = '0;
        end else if (reject_c) begin
            reject_d = 1'b1;
            if (rej_cnt_q != '1) rej_cnt_d = rej_cnt_q + REJ_CNT_W'(1);
        end else if (accept_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (!full_c) fill_d = fill_q + FILL_W'(1);
            // Bypass shows raw events; average mode only publishes once the window is full
            if (bypass_c) begin
                avg_d       = ev_c;
                out_valid_d = 1'b1;
            end else if (fill_d == FILL_W'(DEPTH)) begin
                avg_d       = '{t: avg_t_c, y: avg_y_c, x: avg_x_c};
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            rej_cnt_q   <= '0;
            avg_q       <= '0;
            out_valid_q <= 1'b0;
            reject_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            rej_cnt_q   <= rej_cnt_d;
            avg_q       <= avg_d;
            out_valid_q <= out_valid_d;
            reject_q    <= reject_d;
        end
    end

    always_comb begin
        pins.uo_out                         = 8'(avg_q);
        pins.uo_out[OUT_VALID_BIT]          = out_valid_q;
        pins.uo_out[REJECT_BIT]             = reject_q;
        pins.uio_out                        = '0;
        pins.uio_out[REJ_CNT_LSB +: REJ_CNT_W] = rej_cnt_q;
        pins.uio_oe                         = 8'hF0;
    end

endmodule

// File: tb/tb_event_window_denoiser.sv
// Scoreboard bench: a queue-based window model predicts every cycle's pins; a negedge monitor compares.
module tb_event_window_denoiser;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    event_window_denoiser_if pins();

    event_window_denoiser dut (.clk(clk), .rst_n(rst_n), .pins(pins));

    typedef struct {
        logic [7:0] uo;
        logic [7:0] uio;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // Reference: last DEPTH accepted values per channel, oldest at the front
    int win[3][$];
    int m_avg[3];
    int m_cnt;
    bit m_ov, m_rj;

    function automatic int wsum(int c);
        int s = 0;
        for (int i = 0; i < win[c].size(); i++) s += win[c][i];
        return s;
    endfunction

    function automatic void model_clear();
        for (int c = 0; c < 3; c++) begin
            win[c].delete();
            m_avg[c] = 0;
        end
        m_cnt = 0;
    endfunction

    function automatic void model_step(bit e, logic [7:0] ui, logic [7:0] uio);
        int  nv[3];
        int  thr, d;
        bit  full, far;
        nv[0] = int'(ui[1:0]);
        nv[1] = int'(ui[3:2]);
        nv[2] = int'(ui[5:4]);
        thr   = int'(uio[1:0]);
        m_ov  = 1'b0;
        m_rj  = 1'b0;
        if (!rst_n) begin
            model_clear();
        end else if (e && uio[2]) begin
            model_clear();
        end else if (e && ui[6]) begin
            full = (win[0].size() == 4);
            far  = 1'b0;
            for (int c = 0; c < 3; c++) begin
                d = nv[c] - wsum(c) / 4;
                if (d < 0) d = -d;
                if (d > thr) far = 1'b1;
            end
            if (!ui[7] && full && thr != 0 && far) begin
                m_rj = 1'b1;
                if (m_cnt < 15) m_cnt++;
            end else begin
                for (int c = 0; c < 3; c++) begin
                    if (full) void'(win[c].pop_front());
                    win[c].push_back(nv[c]);
                end
                if (ui[7]) begin
                    for (int c = 0; c < 3; c++) m_avg[c] = nv[c];
                    m_ov = 1'b1;
                end else if (win[0].size() == 4) begin
                    for (int c = 0; c < 3; c++) m_avg[c] = wsum(c) / 4;
                    m_ov = 1'b1;
                end
            end
        end
    endfunction

    function automatic void check(string name, logic [7:0] got, logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endfunction

    // Drive one cycle of inputs; the expectation for that edge is queued at the edge
    task automatic cyc(bit e, logic [7:0] ui, logic [7:0] uio);
        exp_t x;
        pins.ena    = e;
        pins.ui_in  = ui;
        pins.uio_in = uio;
        @(posedge clk);
        model_step(e, ui, uio);
        x.uo  = {m_rj, m_ov, 2'(m_avg[2]), 2'(m_avg[1]), 2'(m_avg[0])};
        x.uio = {4'(m_cnt), 4'b0000};
        sbq.push_back(x);
        #1;
    endtask

    task automatic spot(string name, logic [7:0] uo_want, logic [7:0] uio_want);
        @(negedge clk);
        #1;
        check({name, "_uo"}, pins.uo_out, uo_want);
        check({name, "_uio"}, pins.uio_out, uio_want);
    endtask

    task automatic do_reset(int n);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) cyc(1'b1, 8'($urandom), 8'($urandom));
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (sbq.size() > 0) begin
            x = sbq.pop_front();
            check("uo_out", pins.uo_out, x.uo);
            check("uio_out", pins.uio_out, x.uio);
            check("uio_oe", pins.uio_oe, 8'hF0);
        end
    end

    initial begin
        model_clear();
        pins.ena    = 1'b0;
        pins.ui_in  = '0;
        pins.uio_in = '0;
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'($urandom), 8'($urandom));
        spot("reset", 8'h00, 8'h00);
        rst_n = 1'b1;

        // Warm-up: x=3,y=1,t=2, only the 4th event publishes
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h67, 8'h00);
        spot("warmup3", 8'h00, 8'h00);
        cyc(1'b1, 8'h67, 8'h00);
        spot("warmup4", 8'h67, 8'h00);

        // Full window of zeros, then x=3 walks the average 0,1,2,3
        cyc(1'b1, 8'h00, 8'h04);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'h40, 8'h00);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'h43, 8'h00);
            spot("walk", 8'(8'h40 + i), 8'h00);
        end

        // Outlier gate and saturating reject counter
        cyc(1'b1, 8'h00, 8'h04);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'h40, 8'h00);
        cyc(1'b1, 8'h43, 8'h01);
        spot("reject1", 8'h80, 8'h10);
        cyc(1'b1, 8'h41, 8'h01);
        spot("accept1", 8'h40, 8'h10);
        for (int i = 0; i < 20; i++) cyc(1'b1, 8'h43, 8'h01);
        spot("rejsat", 8'h80, 8'hF0);

        // Bypass on an empty window
        cyc(1'b1, 8'h00, 8'h04);
        cyc(1'b1, 8'hDE, 8'h00);
        spot("bypass", 8'h5E, 8'h00);

        // Clear beats a simultaneous event; ena low holds everything
        cyc(1'b1, 8'h43, 8'h04);
        spot("clr_event", 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h43, 8'h00);
        cyc(1'b0, 8'h43, 8'h04);
        spot("ena_low", 8'h00, 8'h00);
        cyc(1'b1, 8'h43, 8'h00);
        spot("fill_after_clr", 8'h43, 8'h00);

        // Reset after two events restarts warm-up
        cyc(1'b1, 8'h00, 8'h04);
        cyc(1'b1, 8'h55, 8'h00);
        cyc(1'b1, 8'h55, 8'h00);
        do_reset(2);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h55, 8'h00);
        spot("rst_warm3", 8'h00, 8'h00);
        cyc(1'b1, 8'h55, 8'h00);
        spot("rst_warm4", 8'h55, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] ui, uio;
            bit e;
            if ($urandom_range(0, 199) == 0) do_reset($urandom_range(1, 3));
            e      = ($urandom_range(0, 9) != 0);
            ui     = 8'($urandom);
            ui[6]  = ($urandom_range(0, 9) < 7);
            ui[7]  = ($urandom_range(0, 7) == 0);
            uio    = 8'($urandom);
            uio[2] = ($urandom_range(0, 39) == 0);
            cyc(e, ui, uio);
        end

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
